// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding and datapath width shared by the ALU slice
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_4bit_if.sv
// rtl/alu_4bit_if.sv - operand/opcode inputs and registered result/flag outputs of the ALU
interface alu_4bit_if;
  import alu_pkg::*;

  logic [ALU_W-1:0] A;
  logic [ALU_W-1:0] B;
  logic [1:0]       ALU_Sel;
  logic [ALU_W-1:0] Result;
  logic             CarryOut;
  logic             Zero;
  logic             Overflow;

  modport master (
    output A, B, ALU_Sel,
    input  Result, CarryOut, Zero, Overflow
  );

  modport slave (
    input  A, B, ALU_Sel,
    output Result, CarryOut, Zero, Overflow
  );
endinterface

// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - ripple-carry adder shared by ADD and SUB (SUB feeds ~B with cin=1)
module adder_4bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  output logic [ALU_W-1:0] sum,
  output logic             cout
);

  logic [ALU_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < ALU_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[ALU_W];
  end

endmodule

// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - registered 4-bit ALU: opcode mux, flag logic and output registers
module alu_4bit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_4bit_if.slave  bus
);

  alu_op_e          op;
  logic             is_sub;
  logic [ALU_W-1:0] add_b;
  logic [ALU_W-1:0] add_sum;
  logic             add_cout;

  logic [ALU_W-1:0] next_result;
  logic             next_carry;
  logic             next_ovf;

  assign op     = alu_op_e'(bus.ALU_Sel);
  assign is_sub = (op == ALU_SUB);
  assign add_b  = is_sub ? ~bus.B : bus.B;

  adder_4bit u_adder (
    .a    (bus.A),
    .b    (add_b),
    .cin  (is_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    next_ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        next_result = add_sum;
        next_carry  = add_cout;
        next_ovf    = (bus.A[ALU_W-1] == bus.B[ALU_W-1]) && (add_sum[ALU_W-1] != bus.A[ALU_W-1]);
      end
      ALU_SUB: begin
        // A + ~B + 1 carries out exactly when no borrow occurred
        next_result = add_sum;
        next_carry  = ~add_cout;
        next_ovf    = (bus.A[ALU_W-1] != bus.B[ALU_W-1]) && (add_sum[ALU_W-1] != bus.A[ALU_W-1]);
      end
      ALU_AND: next_result = bus.A & bus.B;
      ALU_OR:  next_result = bus.A | bus.B;
      default: next_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Result   <= '0;
      bus.CarryOut <= 1'b0;
      bus.Zero     <= 1'b1;
      bus.Overflow <= 1'b0;
    end else begin
      bus.Result   <= next_result;
      bus.CarryOut <= next_carry;
      bus.Zero     <= (next_result == '0);
      bus.Overflow <= next_ovf;
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// tb/tb_alu_4bit.sv - directed and randomized self-checking bench for alu_4bit
module tb_alu_4bit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_4bit_if bus ();

  alu_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] observed();
    return {bus.Result, bus.CarryOut, bus.Zero, bus.Overflow};
  endfunction

  // Independent integer reference: {Result, CarryOut, Zero, Overflow}
  function automatic logic [6:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] sel);
    int ia, ib, sa, sb, s, sv;
    logic [3:0] r;
    logic c, v;
    ia = {28'd0, a};
    ib = {28'd0, b};
    sa = a[3] ? ia - 16 : ia;
    sb = b[3] ? ib - 16 : ib;
    c  = 1'b0;
    v  = 1'b0;
    case (sel)
      2'b00: begin s = ia + ib; r = s[3:0]; c = (s > 15); sv = sa + sb; v = (sv > 7) || (sv < -8); end
      2'b01: begin s = ia - ib; r = s[3:0]; c = (ia < ib); sv = sa - sb; v = (sv > 7) || (sv < -8); end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r, c, (r == 4'd0), v};
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    @(negedge clk);
    bus.A       = a;
    bus.B       = b;
    bus.ALU_Sel = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(4'b1111, 4'b0001, 2'b00);
      checks++;
      if (observed() !== 7'b0000_0_1_0) begin
        errors++;
        $display("FAIL reset_edge%0d: got %b expected %b", i, observed(), 7'b0000_0_1_0);
      end
    end
    @(negedge clk);
    rst         = 1'b0;
    bus.A       = 4'b0101;
    bus.B       = 4'b0011;
    bus.ALU_Sel = 2'b00;
    #1;
    checks++;
    if (observed() !== 7'b0000_0_1_0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", observed(), 7'b0000_0_1_0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== 7'b1000_0_0_1) begin
      errors++;
      $display("FAIL reset_release_first_op: got %b expected %b", observed(), 7'b1000_0_0_1);
    end
  endtask

  task automatic test_add();
    logic [3:0] ta [4] = '{4'b0101, 4'b1111, 4'b0111, 4'b1000};
    logic [3:0] tb [4] = '{4'b0011, 4'b0001, 4'b0001, 4'b1000};
    logic [6:0] te [4] = '{7'b1000_0_0_1, 7'b0000_1_1_0, 7'b1000_0_0_1, 7'b0000_1_1_1};
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], 2'b00);
      checks++;
      if (observed() !== te[i]) begin
        errors++;
        $display("FAIL add_%0d: got %b expected %b", i, observed(), te[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [3:0] ta [4] = '{4'b1010, 4'b0011, 4'b0110, 4'b0000};
    logic [3:0] tb [4] = '{4'b0101, 4'b0101, 4'b0110, 4'b0001};
    logic [6:0] te [4] = '{7'b0101_0_0_1, 7'b1110_1_0_0, 7'b0000_0_1_0, 7'b1111_1_0_0};
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], 2'b01);
      checks++;
      if (observed() !== te[i]) begin
        errors++;
        $display("FAIL sub_%0d: got %b expected %b", i, observed(), te[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0] ta [4] = '{4'b1100, 4'b1100, 4'b0101, 4'b0000};
    logic [3:0] tb [4] = '{4'b1010, 4'b1010, 4'b1010, 4'b0000};
    logic [1:0] ts [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    logic [6:0] te [4] = '{7'b1000_0_0_0, 7'b1110_0_0_0, 7'b0000_0_1_0, 7'b0000_0_1_0};
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], ts[i]);
      checks++;
      if (observed() !== te[i]) begin
        errors++;
        $display("FAIL logic_%0d: got %b expected %b", i, observed(), te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] prev_exp;
    logic [6:0] exp;
    logic [3:0] a, b;
    logic [1:0] sel;
    prev_exp = observed();
    for (int i = 0; i < 1024; i++) begin
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      sel = 2'(i % 4);
      @(negedge clk);
      bus.A       = a;
      bus.B       = b;
      bus.ALU_Sel = sel;
      exp         = ref_model(a, b, sel);
      #1;
      checks++;
      if (observed() !== prev_exp) begin
        errors++;
        $display("FAIL b2b_hold_%0d: got %b expected %b", i, observed(), prev_exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL b2b_op_%0d a=%b b=%b sel=%b: got %b expected %b", i, a, b, sel, observed(), exp);
      end
      prev_exp = exp;
    end
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 2'b00);
    checks++;
    if (observed() !== 7'b0000_0_1_0) begin
      errors++;
      $display("FAIL midstream_reset: got %b expected %b", observed(), 7'b0000_0_1_0);
    end
    rst = 1'b0;
    drive(4'b0011, 4'b0101, 2'b01);
    checks++;
    if (observed() !== 7'b1110_1_0_0) begin
      errors++;
      $display("FAIL after_midstream_reset: got %b expected %b", observed(), 7'b1110_1_0_0);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.A       = 4'b0000;
    bus.B       = 4'b0000;
    bus.ALU_Sel = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
